d_sram_axi_bridge: RTL and testbench
====================================

Name: d_sram_axi_bridge

Overview:
- Converts the data cache's SRAM-like memory port (req/wr/size/addr/wdata, addr_ok/data_ok) into single-beat AXI3 read and write channels.
- Sits directly downstream of the 2-way write-back data cache; its sram-side ports connect 1:1 to the cache's cache_data_* ports.
- One outstanding transaction at a time, in-order by construction.
- AXI fields not listed here (id, len, burst, lock, cache, prot, last) are tied off by the top-level wrapper: id = 1, len = 0, burst = INCR, wlast = 1.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width. Only 32 is supported; wstrb is DATA_W/8 = 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- data_req  in  1  sram-side request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  byte address
- data_wdata  in  DATA_W  write data, already lane-aligned by the cache
- data_rdata  out  DATA_W  read data, valid with data_ok
- data_addr_ok  out  1  request accepted
- data_data_ok  out  1  transaction complete
- araddr  out  ADDR_W  AXI read address
- arsize  out  3  equal to {1'b0, size}
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rdata  in  DATA_W  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- awaddr  out  ADDR_W  AXI write address
- awsize  out  3  equal to {1'b0, size}
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- wdata  out  DATA_W  AXI write data
- wstrb  out  4  AXI write strobes
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- bresp  in  2  AXI write response
- bvalid  in  1  AXI B valid
- bready  out  1  AXI B ready

Behaviour:
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- **Reset:** state = IDLE. arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok all 0. Latched request registers cleared.
- **Reset mid-transaction:** abandon immediately and return to IDLE. No AXI completion is awaited; the slave is reset in the same cycle.
- **Acceptance:** data_addr_ok = data_req & (state == IDLE), combinational. On acceptance, latch wr, size, addr, wdata and wstrb. The next state is RD_ADDR if wr = 0, otherwise WR_REQ.
- **wstrb:**
  - size 0: one-hot of addr[1:0].
  - size 1: 4'b0011 if addr[1] = 0, else 4'b1100.
  - size 2 or 3: 4'b1111.
- **Address:** araddr and awaddr are the latched addr, unmodified.
- **RD_ADDR:**
  - arvalid = 1 and held until arready.
  - On arready, go to RD_DATA.
- **RD_DATA:**
  - rready = 1.
  - On rvalid: data_data_ok = 1 for exactly that cycle, data_rdata = rdata (combinational pass-through), next state IDLE.
  - data_rdata is 0 whenever data_data_ok = 0.
- **WR_REQ:**
  - awvalid and wvalid are asserted and dropped independently.
  - Flags aw_done and w_done record each handshake. Either order, or both in the same cycle, is legal.
  - When both handshakes are done (including the completing cycle), go to WR_RESP and clear the flags.
- **WR_RESP:**
  - bready = 1.
  - On bvalid: data_data_ok = 1 for one cycle, next state IDLE.
- **Responses:** non-OKAY rresp/bresp is ignored; completion proceeds normally.
- **Back-to-back requests:** a request held through completion is accepted in the cycle after data_data_ok, so the minimum IDLE gap is one cycle.
- **Minimum latency** (zero-wait slave):
  - Read: addr_ok in cycle 0, AR handshake in cycle 1, data_ok in cycle 2.
  - Write: addr_ok in cycle 0, AW and W in cycle 1, data_ok in cycle 2.
- **Held outputs:** arvalid, awvalid and wvalid never drop before their ready. Address, size, data and strobes are stable while valid is high.

Optional Feature:
- **Macro:** SRAM_AXI_POSTED_WR_EN.
- **Defined:**
  - A write's data_data_ok pulses in the cycle both AW and W handshakes are complete.
  - The FSM then enters WR_RESP with bready = 1.
  - data_addr_ok is held 0 until bvalid, so a following read cannot overtake the write.
  - A request arriving in the bvalid cycle is not accepted until the next IDLE cycle.
- **Undefined:** data_data_ok for writes is issued only on bvalid, as specified above.

Decomposition:
- **Package d_sram_axi_pkg:**
  - State enum.
  - SIZE_BYTE/HALF/WORD constants.
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00.
  - Tie-off ID = 4'd1.
- **Sub-module sram_wstrb_gen:** combinational mapping of (size, addr[1:0]) to wstrb. It is reused by the instruction-side bridge.

Test Plan:
- Read addr 0x1000_0004, size 2, zero-wait slave returning 0xDEADBEEF -> arvalid in cycle 1, arsize = 3'b010; data_ok and rdata = 0xDEADBEEF in cycle 2.
- Write byte addr 0x0000_0013, wdata 0xAB000000 -> wstrb = 4'b1000, awaddr = 0x13; data_ok on the bvalid cycle, exactly one pulse.
- AW ready 3 cycles before W ready, then the reverse order -> each valid drops after its own handshake; WR_RESP is entered only once both are done.
- arready and rvalid each delayed 5 cycles, req held high -> addr_ok is a single pulse; no second AR is issued until data_ok.
- rst asserted in RD_DATA, then released -> all valids and readys are 0 during reset; a fresh read is accepted in the first cycle after reset.
- With SRAM_AXI_POSTED_WR_EN: write, then an immediate read with bvalid delayed 4 cycles -> write data_ok in cycle 1 or 2; read addr_ok is held 0 until after bvalid.

Source files
------------

// File: rtl/d_sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI bridges.
// AXI tie-offs (id/len/burst/last) are applied by the wrapper above the bridge.
package d_sram_axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP
   } state_e;

   localparam logic [1:0] SIZE_BYTE  = 2'd0;
   localparam logic [1:0] SIZE_HALF  = 2'd1;
   localparam logic [1:0] SIZE_WORD  = 2'd2;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_ID     = 4'd1;

endpackage

// File: rtl/d_sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe generation from SRAM access size and low address bits.
// Shared with the instruction-side bridge.
module sram_wstrb_gen
   import d_sram_axi_pkg::*;
(
   input  logic [1:0] size_i,
   input  logic [1:0] addr_i,
   output logic [3:0] wstrb_o
);

   always_comb begin
      wstrb_o = 4'b1111;
      case (size_i)
         SIZE_BYTE: wstrb_o = 4'b0001 << addr_i;
         SIZE_HALF: wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
         default:   wstrb_o = 4'b1111;
      endcase
   end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Data-cache SRAM-like port to single-beat AXI3 bridge, one transaction in flight.
// Define SRAM_AXI_POSTED_WR_EN to complete writes on AW+W instead of on B.
module d_sram_axi_bridge
   import d_sram_axi_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,

   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arsize,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,

   output logic [ADDR_W-1:0] awaddr,
   output logic [2:0]        awsize,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   state_e            state_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        wstrb_q;
   logic              arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
   logic              aw_done_q, w_done_q;
   logic              aw_done_d, w_done_d;

   logic [3:0]        wstrb_d;
   logic              aw_hs, w_hs, wr_both, rd_ok, b_ok;

   sram_wstrb_gen u_wstrb_gen (
      .size_i  (data_size),
      .addr_i  (data_addr[1:0]),
      .wstrb_o (wstrb_d)
   );

   assign aw_hs     = awvalid_q & awready;
   assign w_hs      = wvalid_q & wready;
   assign aw_done_d = aw_done_q | aw_hs;
   assign w_done_d  = w_done_q | w_hs;
   assign wr_both   = (state_q == WR_REQ) & aw_done_d & w_done_d;

   // Error responses complete exactly like OKAY; the response code is deliberately don't-care.
   assign rd_ok = (state_q == RD_DATA) & rvalid & ((rresp == RESP_OKAY) | (rresp != RESP_OKAY));
   assign b_ok  = (state_q == WR_RESP) & bvalid & ((bresp == RESP_OKAY) | (bresp != RESP_OKAY));

   assign data_addr_ok = ~rst & data_req & (state_q == IDLE);
`ifdef SRAM_AXI_POSTED_WR_EN
   assign data_data_ok = ~rst & (rd_ok | wr_both);
`else
   assign data_data_ok = ~rst & (rd_ok | b_ok);
`endif
   assign data_rdata   = (~rst & rd_ok) ? rdata : '0;

   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign awsize  = {1'b0, size_q};
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign arvalid = arvalid_q;
   assign awvalid = awvalid_q;
   assign wvalid  = wvalid_q;
   assign rready  = rready_q;
   assign bready  = bready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         size_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rready_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_req) begin
                  size_q  <= data_size;
                  addr_q  <= data_addr;
                  wdata_q <= data_wdata;
                  wstrb_q <= wstrb_d;
                  if (data_wr) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rd_ok) begin
                  rready_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            WR_REQ: begin
               if (aw_hs) awvalid_q <= 1'b0;
               if (w_hs)  wvalid_q  <= 1'b0;
               // The completing handshake counts in the same cycle, so flags never need to show both set.
               if (wr_both) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= WR_RESP;
               end else begin
                  aw_done_q <= aw_done_d;
                  w_done_q  <= w_done_d;
               end
            end
            WR_RESP: begin
               if (b_ok) begin
                  bready_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Directed bench for d_sram_axi_bridge; honours SRAM_AXI_POSTED_WR_EN when defined.
module tb_d_sram_axi_bridge;

`ifdef SRAM_AXI_POSTED_WR_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   d_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd,
                          input int unsigned ar_dly, input int unsigned r_dly, input bit hold);
      data_req = 1'b1; data_wr = 1'b0; data_size = sz; data_addr = a; data_wdata = '0;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rdata = 32'h5555_AAAA;
      #1;
      check_eq("rd_addr_ok", 32'(data_addr_ok), 32'd1);
      check_eq("rd_arvalid_c0", 32'(arvalid), 32'd0);
      step();
      for (int unsigned c = 0; c <= ar_dly; c++) begin
         data_req = hold; data_addr = ~a;
         arready  = (c == ar_dly);
         #1;
         check_eq("rd_arvalid", 32'(arvalid), 32'd1);
         check_eq("rd_araddr", araddr, a);
         check_eq("rd_arsize", 32'(arsize), 32'({1'b0, sz}));
         check_eq("rd_rready_early", 32'(rready), 32'd0);
         check_eq("rd_addr_ok_busy", 32'(data_addr_ok), 32'd0);
         check_eq("rd_data_ok_early", 32'(data_data_ok), 32'd0);
         step();
      end
      arready = 1'b0;
      for (int unsigned k = 0; k <= r_dly; k++) begin
         rvalid = (k == r_dly);
         rdata  = (k == r_dly) ? rd : 32'h5555_AAAA;
         rresp  = (k == r_dly) ? 2'b10 : 2'b00;
         #1;
         check_eq("rd_rready", 32'(rready), 32'd1);
         check_eq("rd_no_second_ar", 32'(arvalid), 32'd0);
         check_eq("rd_data_ok", 32'(data_data_ok), 32'(k == r_dly));
         check_eq("rd_rdata", data_rdata, (k == r_dly) ? rd : 32'd0);
         check_eq("rd_addr_ok_wait", 32'(data_addr_ok), 32'd0);
         step();
      end
      rvalid = 1'b0; rresp = 2'b00; data_req = hold;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input logic [3:0] exp_strb, input int unsigned aw_dly,
                           input int unsigned w_dly, input int unsigned b_dly, input bit next_req);
      int unsigned last;
      last = (aw_dly > w_dly) ? aw_dly : w_dly;
      data_req = 1'b1; data_wr = 1'b1; data_size = sz; data_addr = a; data_wdata = wd;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      #1;
      check_eq("wr_addr_ok", 32'(data_addr_ok), 32'd1);
      step();
      for (int unsigned c = 0; c <= last; c++) begin
         data_req = 1'b0; data_wr = 1'b0; data_addr = ~a; data_wdata = ~wd;
         awready = (c == aw_dly);
         wready  = (c == w_dly);
         #1;
         check_eq("wr_awvalid", 32'(awvalid), 32'(c <= aw_dly));
         check_eq("wr_wvalid", 32'(wvalid), 32'(c <= w_dly));
         if (c <= aw_dly) begin
            check_eq("wr_awaddr", awaddr, a);
            check_eq("wr_awsize", 32'(awsize), 32'({1'b0, sz}));
         end
         if (c <= w_dly) begin
            check_eq("wr_wdata", wdata, wd);
            check_eq("wr_wstrb", 32'(wstrb), 32'(exp_strb));
         end
         check_eq("wr_bready_early", 32'(bready), 32'd0);
         check_eq("wr_data_ok_req", 32'(data_data_ok), 32'(POSTED && (c == last)));
         step();
      end
      awready = 1'b0; wready = 1'b0;
      for (int unsigned k = 0; k <= b_dly; k++) begin
         data_req = next_req; data_wr = 1'b0;
         bvalid = (k == b_dly);
         bresp  = (k == b_dly) ? 2'b11 : 2'b00;
         #1;
         check_eq("wr_bready", 32'(bready), 32'd1);
         check_eq("wr_valids_low", 32'({awvalid, wvalid}), 32'd0);
         check_eq("wr_data_ok_resp", 32'(data_data_ok), 32'(!POSTED && (k == b_dly)));
         check_eq("wr_addr_ok_hold", 32'(data_addr_ok), 32'd0);
         check_eq("wr_rdata_zero", data_rdata, 32'd0);
         step();
      end
      bvalid = 1'b0; bresp = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
      arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
      step(); step();
      check_eq("rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
      check_eq("rst_readys", 32'({rready, bready}), 32'd0);
      check_eq("rst_addr_ok", 32'(data_addr_ok), 32'd0);
      check_eq("rst_data_ok", 32'(data_data_ok), 32'd0);
      rst = 1'b0; data_req = 1'b0;
      #1;
      check_eq("idle_addr_ok", 32'(data_addr_ok), 32'd0);
      step();

      do_read(32'h1000_0004, 2'd2, 32'hDEAD_BEEF, 0, 0, 1'b0);
      do_write(32'h0000_0013, 2'd0, 32'hAB00_0000, 4'b1000, 0, 0, 1, 1'b0);
      do_write(32'h0000_0022, 2'd1, 32'h1234_0000, 4'b1100, 0, 3, 0, 1'b0);
      do_write(32'h0000_0021, 2'd0, 32'h0000_CD00, 4'b0010, 3, 0, 0, 1'b0);
      do_write(32'h0000_0040, 2'd3, 32'h1122_3344, 4'b1111, 1, 1, 0, 1'b0);
      do_write(32'h0000_0044, 2'd1, 32'h0000_5566, 4'b0011, 0, 0, 0, 1'b0);

      // held request: single addr_ok per transaction, back-to-back acceptance after data_ok
      do_read(32'h2000_0102, 2'd1, 32'h0000_BEEF, 5, 5, 1'b1);
      do_read(32'h0000_0300, 2'd0, 32'h0000_0077, 0, 0, 1'b0);

      // write followed by a read waiting through a slow B response
      do_write(32'h0000_0050, 2'd2, 32'h0BAD_F00D, 4'b1111, 0, 0, 4, 1'b1);
      do_read(32'h0000_0050, 2'd2, 32'h0BAD_F00D, 0, 0, 1'b0);

      // reset in RD_DATA
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h60;
      #1;
      check_eq("rrst_addr_ok", 32'(data_addr_ok), 32'd1);
      step();
      data_req = 1'b0; arready = 1'b1;
      step();
      arready = 1'b0;
      #1;
      check_eq("rrst_in_rd_data", 32'(rready), 32'd1);
      rst = 1'b1; data_req = 1'b1; rvalid = 1'b1;
      step();
      check_eq("rrst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
      check_eq("rrst_readys", 32'({rready, bready}), 32'd0);
      check_eq("rrst_data_ok", 32'(data_data_ok), 32'd0);
      check_eq("rrst_addr_ok", 32'(data_addr_ok), 32'd0);
      step();
      rst = 1'b0; rvalid = 1'b0;
      do_read(32'h0000_0070, 2'd2, 32'hCAFE_F00D, 0, 0, 1'b0);

      data_req = 1'b0;
      #1;
      check_eq("end_idle_data_ok", 32'(data_data_ok), 32'd0);
      check_eq("end_idle_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
